// File: rtl/hold_ctrl_pkg.sv
// Shared pipeline hold/flush definitions: the hold_flag bus type and its codes,
// plus the hold controller state encoding.
package hold_ctrl_pkg;

    typedef logic [2:0] HoldFlagBus;

    // Codes seen by every pipeline register on the hold_flag bus
    localparam HoldFlagBus HOLD_RUN        = 3'b000;
    localparam HoldFlagBus HOLD_STALL      = 3'b001;
    localparam HoldFlagBus HOLD_FLUSH_IFID = 3'b010;
    localparam HoldFlagBus HOLD_FLUSH_IFEX = 3'b011;
    localparam HoldFlagBus HOLD_FLUSH_ALL  = 3'b100;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_FLUSH,
        ST_TRAP,
        ST_MEM_STALL,
        ST_DIV_STALL
    } hold_state_t;

endpackage

// File: rtl/hold_ctrl.sv
// Pipeline hold controller: arbitrates trap/jump redirects and memory/divide
// stalls into a registered hold_flag code plus one-cycle redirect pulses.
module hold_ctrl
    import hold_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_req,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  jump_ack,
    input  logic                  trap_req,
    input  logic [ADDR_WIDTH-1:0] trap_addr,
    output logic                  trap_ack,
    input  logic                  mem_req,
    input  logic                  mem_ack,
    input  logic                  div_start,
    input  logic                  div_done,
    output HoldFlagBus            hold_flag,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_addr
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 2);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] TRAP_LOAD  = CNT_W'(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    hold_state_t           r_state;
    logic [CNT_W-1:0]      r_count;
    HoldFlagBus            r_hold_flag;
    logic                  r_jump_ack;
    logic                  r_trap_ack;
    logic                  r_redirect_valid;
    logic [ADDR_WIDTH-1:0] r_redirect_addr;

    hold_state_t           w_state_next;
    logic [CNT_W-1:0]      w_count_next;
    HoldFlagBus            w_hold_next;
    logic                  w_jump_ack_next;
    logic                  w_trap_ack_next;
    logic                  w_redirect_valid_next;
    logic [ADDR_WIDTH-1:0] w_redirect_addr_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= ST_RUN;
            r_count          <= '0;
            r_hold_flag      <= HOLD_RUN;
            r_jump_ack       <= 1'b0;
            r_trap_ack       <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_addr  <= '0;
        end else begin
            r_state          <= w_state_next;
            r_count          <= w_count_next;
            r_hold_flag      <= w_hold_next;
            r_jump_ack       <= w_jump_ack_next;
            r_trap_ack       <= w_trap_ack_next;
            r_redirect_valid <= w_redirect_valid_next;
            r_redirect_addr  <= w_redirect_addr_next;
        end
    end

    // A trap wins from any state and abandons whatever flush or stall is in progress.
    always_comb begin
        w_state_next          = ST_RUN;
        w_count_next          = '0;
        w_hold_next           = HOLD_RUN;
        w_jump_ack_next       = 1'b0;
        w_trap_ack_next       = 1'b0;
        w_redirect_valid_next = 1'b0;
        w_redirect_addr_next  = r_redirect_addr;

        if (trap_req) begin
            w_state_next          = ST_TRAP;
            w_count_next          = TRAP_LOAD;
            w_hold_next           = HOLD_FLUSH_ALL;
            w_trap_ack_next       = 1'b1;
            w_redirect_valid_next = 1'b1;
            w_redirect_addr_next  = trap_addr;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (jump_req) begin
                        w_state_next          = ST_FLUSH;
                        w_count_next          = FLUSH_LOAD;
                        w_hold_next           = HOLD_FLUSH_IFEX;
                        w_jump_ack_next       = 1'b1;
                        w_redirect_valid_next = 1'b1;
                        w_redirect_addr_next  = jump_addr;
                    end else if (mem_req && !mem_ack) begin
                        w_state_next = ST_MEM_STALL;
                        w_hold_next  = HOLD_STALL;
                    end else if (div_start) begin
                        w_state_next = ST_DIV_STALL;
                        w_hold_next  = HOLD_STALL;
                    end
                end
                // Exit at a count of one (or below) so the counter can never wrap.
                ST_FLUSH: begin
                    if (r_count > CNT_ONE) begin
                        w_state_next = ST_FLUSH;
                        w_count_next = r_count - CNT_ONE;
                        w_hold_next  = HOLD_FLUSH_IFEX;
                    end
                end
                ST_TRAP: begin
                    if (r_count > CNT_ONE) begin
                        w_state_next = ST_TRAP;
                        w_count_next = r_count - CNT_ONE;
                        w_hold_next  = HOLD_FLUSH_ALL;
                    end
                end
                ST_MEM_STALL: begin
                    if (!mem_ack) begin
                        w_state_next = ST_MEM_STALL;
                        w_hold_next  = HOLD_STALL;
                    end
                end
                ST_DIV_STALL: begin
                    if (!div_done) begin
                        w_state_next = ST_DIV_STALL;
                        w_hold_next  = HOLD_STALL;
                    end
                end
                default: w_state_next = ST_RUN;
            endcase
        end
    end

    assign hold_flag      = r_hold_flag;
    assign jump_ack       = r_jump_ack;
    assign trap_ack       = r_trap_ack;
    assign redirect_valid = r_redirect_valid;
    assign redirect_addr  = r_redirect_addr;

endmodule

// File: tb/tb_hold_ctrl.sv
// Scoreboard bench for hold_ctrl: each scenario queues per-cycle stimulus with
// the outputs expected after that edge, then replays and compares them.
module tb_hold_ctrl;
    import hold_ctrl_pkg::*;

    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          jump_req = 1'b0;
    logic [AW-1:0] jump_addr = '0;
    logic          jump_ack;
    logic          trap_req = 1'b0;
    logic [AW-1:0] trap_addr = '0;
    logic          trap_ack;
    logic          mem_req = 1'b0;
    logic          mem_ack = 1'b0;
    logic          div_start = 1'b0;
    logic          div_done = 1'b0;
    HoldFlagBus    hold_flag;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;

    hold_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .jump_req(jump_req), .jump_addr(jump_addr), .jump_ack(jump_ack),
        .trap_req(trap_req), .trap_addr(trap_addr), .trap_ack(trap_ack),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .div_start(div_start), .div_done(div_done),
        .hold_flag(hold_flag),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          jreq;
        logic [AW-1:0] jaddr;
        logic          treq;
        logic [AW-1:0] taddr;
        logic          mreq;
        logic          mack;
        logic          dstart;
        logic          ddone;
    } stim_t;

    typedef struct packed {
        logic [2:0]    hold;
        logic          jack;
        logic          tack;
        logic          rv;
        logic [AW-1:0] addr;
    } resp_t;

    stim_t stimQ[$];
    resp_t expQ[$];
    int    checks = 0;
    int    failures = 0;

    function automatic resp_t R(input logic [2:0] h, input logic ja, input logic ta,
                                input logic rv, input logic [AW-1:0] a);
        resp_t r;
        r.hold = h; r.jack = ja; r.tack = ta; r.rv = rv; r.addr = a;
        return r;
    endfunction

    task automatic push(input stim_t s, input resp_t r);
        stimQ.push_back(s);
        expQ.push_back(r);
    endtask

    task automatic drive(input stim_t s);
        jump_req  = s.jreq;  jump_addr = s.jaddr;
        trap_req  = s.treq;  trap_addr = s.taddr;
        mem_req   = s.mreq;  mem_ack   = s.mack;
        div_start = s.dstart; div_done = s.ddone;
    endtask

    function automatic resp_t observed();
        return {hold_flag, jump_ack, trap_ack, redirect_valid, redirect_addr};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++;
        if (observed() !== resp_t'(0)) begin
            failures++;
            $display("FAIL reset_initial got=%h want=0", observed());
        end
        @(posedge clk); #1;
        checks++;
        if (observed() !== resp_t'(0)) begin
            failures++;
            $display("FAIL reset_held got=%h want=0", observed());
        end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_jump();
        stim_t s;
        resp_t e;
        s = '0; s.jreq = 1'b1; s.jaddr = 64'h8000_0040;
        push(s, R(HOLD_FLUSH_IFEX, 1, 0, 1, 64'h8000_0040));
        s = '0;
        push(s, R(HOLD_FLUSH_IFEX, 0, 0, 0, 64'h8000_0040));
        push(s, R(HOLD_RUN, 0, 0, 0, 64'h8000_0040));
        push(s, R(HOLD_RUN, 0, 0, 0, 64'h8000_0040));
        for (int c = 0; stimQ.size() > 0; c++) begin
            @(negedge clk) drive(stimQ.pop_front());
            @(posedge clk); #1;
            e = expQ.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL jump c%0d got=%h want=%h", c, observed(), e);
            end
        end
    endtask

    task automatic test_trap_priority();
        stim_t s;
        resp_t e;
        s = '0; s.treq = 1'b1; s.taddr = 64'h100; s.jreq = 1'b1; s.jaddr = 64'h200;
        push(s, R(HOLD_FLUSH_ALL, 0, 1, 1, 64'h100));
        s.treq = 1'b0;
        push(s, R(HOLD_FLUSH_ALL, 0, 0, 0, 64'h100));
        push(s, R(HOLD_FLUSH_ALL, 0, 0, 0, 64'h100));
        push(s, R(HOLD_RUN, 0, 0, 0, 64'h100));
        push(s, R(HOLD_FLUSH_IFEX, 1, 0, 1, 64'h200));
        s = '0;
        push(s, R(HOLD_FLUSH_IFEX, 0, 0, 0, 64'h200));
        push(s, R(HOLD_RUN, 0, 0, 0, 64'h200));
        for (int c = 0; stimQ.size() > 0; c++) begin
            @(negedge clk) drive(stimQ.pop_front());
            @(posedge clk); #1;
            e = expQ.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL trap_priority c%0d got=%h want=%h", c, observed(), e);
            end
        end
    endtask

    task automatic test_mem_stall();
        stim_t s;
        resp_t e;
        s = '0; s.mreq = 1'b1;
        for (int i = 0; i < 4; i++) push(s, R(HOLD_STALL, 0, 0, 0, 64'h200));
        s.mack = 1'b1;
        push(s, R(HOLD_RUN, 0, 0, 0, 64'h200));
        push('0, R(HOLD_RUN, 0, 0, 0, 64'h200));
        push(s, R(HOLD_RUN, 0, 0, 0, 64'h200));
        push('0, R(HOLD_RUN, 0, 0, 0, 64'h200));
        for (int c = 0; stimQ.size() > 0; c++) begin
            @(negedge clk) drive(stimQ.pop_front());
            @(posedge clk); #1;
            e = expQ.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL mem_stall c%0d got=%h want=%h", c, observed(), e);
            end
        end
    endtask

    task automatic test_div_trap();
        stim_t s;
        resp_t e;
        s = '0; s.dstart = 1'b1;
        push(s, R(HOLD_STALL, 0, 0, 0, 64'h200));
        push('0, R(HOLD_STALL, 0, 0, 0, 64'h200));
        s = '0; s.treq = 1'b1; s.taddr = 64'h300;
        push(s, R(HOLD_FLUSH_ALL, 0, 1, 1, 64'h300));
        s = '0; s.ddone = 1'b1;
        push(s, R(HOLD_FLUSH_ALL, 0, 0, 0, 64'h300));
        push(s, R(HOLD_FLUSH_ALL, 0, 0, 0, 64'h300));
        push('0, R(HOLD_RUN, 0, 0, 0, 64'h300));
        push(s, R(HOLD_RUN, 0, 0, 0, 64'h300));
        s = '0; s.dstart = 1'b1;
        push(s, R(HOLD_STALL, 0, 0, 0, 64'h300));
        s = '0; s.ddone = 1'b1;
        push(s, R(HOLD_RUN, 0, 0, 0, 64'h300));
        for (int c = 0; stimQ.size() > 0; c++) begin
            @(negedge clk) drive(stimQ.pop_front());
            @(posedge clk); #1;
            e = expQ.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL div_trap c%0d got=%h want=%h", c, observed(), e);
            end
        end
    endtask

    task automatic test_jump_in_mem_stall();
        stim_t s;
        resp_t e;
        s = '0; s.mreq = 1'b1;
        push(s, R(HOLD_STALL, 0, 0, 0, 64'h300));
        s.jreq = 1'b1; s.jaddr = 64'h400;
        push(s, R(HOLD_STALL, 0, 0, 0, 64'h300));
        s.mack = 1'b1;
        push(s, R(HOLD_RUN, 0, 0, 0, 64'h300));
        s = '0; s.jreq = 1'b1; s.jaddr = 64'h400;
        push(s, R(HOLD_FLUSH_IFEX, 1, 0, 1, 64'h400));
        push('0, R(HOLD_FLUSH_IFEX, 0, 0, 0, 64'h400));
        push('0, R(HOLD_RUN, 0, 0, 0, 64'h400));
        for (int c = 0; stimQ.size() > 0; c++) begin
            @(negedge clk) drive(stimQ.pop_front());
            @(posedge clk); #1;
            e = expQ.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL jump_in_mem_stall c%0d got=%h want=%h", c, observed(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        resp_t e;
        s = '0; s.treq = 1'b1; s.taddr = 64'h500;
        push(s, R(HOLD_FLUSH_ALL, 0, 1, 1, 64'h500));
        push(s, R(HOLD_FLUSH_ALL, 0, 1, 1, 64'h500));
        push('0, R(HOLD_FLUSH_ALL, 0, 0, 0, 64'h500));
        push('0, R(HOLD_FLUSH_ALL, 0, 0, 0, 64'h500));
        push('0, R(HOLD_RUN, 0, 0, 0, 64'h500));
        s = '0; s.jreq = 1'b1; s.jaddr = 64'h600;
        push(s, R(HOLD_FLUSH_IFEX, 1, 0, 1, 64'h600));
        push(s, R(HOLD_FLUSH_IFEX, 0, 0, 0, 64'h600));
        push(s, R(HOLD_RUN, 0, 0, 0, 64'h600));
        push(s, R(HOLD_FLUSH_IFEX, 1, 0, 1, 64'h600));
        push('0, R(HOLD_FLUSH_IFEX, 0, 0, 0, 64'h600));
        push('0, R(HOLD_RUN, 0, 0, 0, 64'h600));
        for (int c = 0; stimQ.size() > 0; c++) begin
            @(negedge clk) drive(stimQ.pop_front());
            @(posedge clk); #1;
            e = expQ.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL back_to_back c%0d got=%h want=%h", c, observed(), e);
            end
        end
    endtask

    task automatic test_reset_mid_trap();
        stim_t s;
        resp_t e;
        s = '0; s.treq = 1'b1; s.taddr = 64'h700;
        push(s, R(HOLD_FLUSH_ALL, 0, 1, 1, 64'h700));
        for (int c = 0; stimQ.size() > 0; c++) begin
            @(negedge clk) drive(stimQ.pop_front());
            @(posedge clk); #1;
            e = expQ.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL reset_mid_trap_entry c%0d got=%h want=%h", c, observed(), e);
            end
        end
        drive('0);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (observed() !== resp_t'(0)) begin
            failures++;
            $display("FAIL reset_async got=%h want=0", observed());
        end
        @(posedge clk); #1;
        @(negedge clk) rst = 1'b1;
        push('0, R(HOLD_RUN, 0, 0, 0, 64'h0));
        push('0, R(HOLD_RUN, 0, 0, 0, 64'h0));
        push('0, R(HOLD_RUN, 0, 0, 0, 64'h0));
        for (int c = 0; stimQ.size() > 0; c++) begin
            @(negedge clk) drive(stimQ.pop_front());
            @(posedge clk); #1;
            e = expQ.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL reset_after c%0d got=%h want=%h", c, observed(), e);
            end
        end
    endtask

    initial begin
        $display("[TB] hold_ctrl scoreboard bench starting");
        test_reset();
        test_jump();
        test_trap_priority();
        test_mem_stall();
        test_div_trap();
        test_jump_in_mem_stall();
        test_back_to_back();
        test_reset_mid_trap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
